// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
//   Multiply/divide sequencer for the E stage of the pipelined MIPS core.
//   Owns the HI/LO architectural registers. One HI/LO-class operation is
//   accepted at a time. The full result is computed when the operation is
//   accepted and committed after a fixed latency. A busy flag models that
//   latency, and md_stall tells the hazard unit to freeze D.
//
// Ports
//   clk       system clock, rising edge
//   reset     asynchronous, active-high; clears all state
//   md_start  E-stage instruction is a valid HI/LO operation this cycle
//   md_op     1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB,
//             8 MSUBU, 9 MTHI, 10 MTLO; 0 and 11-15 do nothing
//   rs_val    forwarded rs operand (multiplicand/dividend, MTHI/MTLO source)
//   rt_val    forwarded rt operand (multiplier/divisor)
//   md_kill   exception/flush: abort the in-flight operation
//   busy      operation in flight
//   md_stall  busy, or a multi-cycle operation is being presented
//   hi, lo    HI and LO registers
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_kill,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   res_q, res_d;
    // Cleared for divide by zero so completion leaves HI/LO untouched.
    logic          res_ok_q, res_ok_d;

    // ---------------------------------------------------------------------
    // Operation decode
    // ---------------------------------------------------------------------
    logic is_md_op;
    logic is_div;
    logic div_by_zero;

    assign is_md_op    = (md_op >= OP_MULT) && (md_op <= OP_MSUBU);
    assign is_div      = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign div_by_zero = is_div && (rt_val == 32'd0);

    // ---------------------------------------------------------------------
    // Result datapath (evaluated on the accept cycle, held in res_q)
    // ---------------------------------------------------------------------
    logic [63:0] acc;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign acc    = {hi_q, lo_q};
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // The signed divide runs on magnitudes and then fixes up the signs. The
    // quotient truncates toward zero and the remainder takes the dividend's
    // sign. 0x80000000 / -1 wraps to 0x80000000 with remainder 0. A zero
    // divisor is replaced by 1 only to keep the divider defined. That result
    // is never committed.
    logic [31:0] dvd_abs;
    logic [31:0] dvs_abs;
    logic [31:0] dvs_abs_safe;
    logic [31:0] dvs_u_safe;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    assign dvd_abs      = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
    assign dvs_abs      = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
    assign dvs_abs_safe = (rt_val == 32'd0) ? 32'd1 : dvs_abs;
    assign dvs_u_safe   = (rt_val == 32'd0) ? 32'd1 : rt_val;

    assign quo_mag = dvd_abs / dvs_abs_safe;
    assign rem_mag = dvd_abs % dvs_abs_safe;
    assign quo_s   = (rs_val[31] ^ rt_val[31]) ? (~quo_mag + 32'd1) : quo_mag;
    assign rem_s   = rs_val[31] ? (~rem_mag + 32'd1) : rem_mag;

    assign quo_u = rs_val / dvs_u_safe;
    assign rem_u = rs_val % dvs_u_safe;

    logic [63:0] result;

    always_comb begin
        result = 64'd0;
        case (md_op)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {rem_s, quo_s};
            OP_DIVU:  result = {rem_u, quo_u};
            OP_MADD:  result = acc + prod_s;
            OP_MADDU: result = acc + prod_u;
            OP_MSUB:  result = acc - prod_s;
            OP_MSUBU: result = acc - prod_u;
            default:  result = 64'd0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_ok_d = res_ok_q;

        case (state_q)
            ST_IDLE: begin
                // A kill in the same cycle wins over any start, MTHI/MTLO included.
                if (md_start && !md_kill) begin
                    if (is_md_op) begin
                        state_d  = ST_BUSY;
                        cnt_d    = is_div ? DIV_LAT : MULT_LAT;
                        res_d    = result;
                        res_ok_d = !div_by_zero;
                    end else if (md_op == OP_MTHI) begin
                        hi_d = rs_val;
                    end else if (md_op == OP_MTLO) begin
                        lo_d = rs_val;
                    end
                end
            end

            ST_BUSY: begin
                // Starts presented while busy are held off by md_stall, so
                // they are ignored here.
                if (md_kill) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (res_ok_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_q    <= 64'd0;
            res_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_ok_q <= res_ok_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy     = (state_q == ST_BUSY);
    // Asserted in the start cycle itself, so the dependent D-stage
    // instruction never samples stale HI/LO.
    assign md_stall = busy | (md_start & is_md_op);
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
//   Self-checking bench for mdu_ctrl. Directed scenarios come first, then
//   randomized operations. Expected HI/LO values come from an arithmetic
//   reference model that uses 64-bit integer math.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5;
    localparam logic [3:0] OP_MSUB  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd9;
    localparam logic [3:0] OP_MTLO  = 4'd10;

    logic        clk;
    logic        reset;
    logic        md_start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_kill;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    mdu_ctrl #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_start(md_start),
        .md_op   (md_op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .md_kill (md_kill),
        .busy    (busy),
        .md_stall(md_stall),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: next HI/LO for one operation, from plain integer math.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         output logic [31:0] nh, output logic [31:0] nl,
                         output bit md, output int lat);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     acc;
        logic [63:0]     ps;
        logic [63:0]     pu;
        logic [63:0]     r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = a;
        ub  = b;
        acc = {h, l};
        ps  = sa * sb;
        pu  = ua * ub;
        nh  = h;
        nl  = l;
        md  = (op >= 4'd1) && (op <= 4'd8);
        lat = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
        r   = acc;
        case (op)
            4'd1: r = ps;
            4'd2: r = pu;
            4'd3: if (b != 0) begin
                nl = 32'(sa / sb);
                nh = 32'(sa % sb);
                r  = {nh, nl};
            end
            4'd4: if (b != 0) r = {a % b, a / b};
            4'd5: r = acc + ps;
            4'd6: r = acc + pu;
            4'd7: r = acc - ps;
            4'd8: r = acc - pu;
            4'd9: r = {a, l};
            4'd10: r = {h, a};
            default: r = acc;
        endcase
        nh = r[63:32];
        nl = r[31:0];
    endtask

    // Present one operation for one cycle and follow it to completion.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nh;
        logic [31:0] nl;
        bit          md;
        int          lat;
        model(op, a, b, exp_hi, exp_lo, nh, nl, md, lat);
        @(negedge clk);
        md_start = 1'b1;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        #1;
        check($sformatf("stall_start op%0d", op), 64'(md_stall), 64'(md));
        @(negedge clk);
        md_start = 1'b0;
        md_op    = OP_NONE;
        if (md) begin
            for (int i = 0; i < lat; i++) begin
                if (i > 0) @(negedge clk);
                check($sformatf("busy op%0d c%0d", op, i), 64'(busy), 64'd1);
                check($sformatf("hold op%0d c%0d", op, i), {hi, lo}, {exp_hi, exp_lo});
            end
            @(negedge clk);
        end
        exp_hi = nh;
        exp_lo = nl;
        check($sformatf("idle op%0d", op), 64'(busy), 64'd0);
        check($sformatf("hi op%0d", op), 64'(hi), 64'(exp_hi));
        check($sformatf("lo op%0d", op), 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        logic [31:0] nh;
        logic [31:0] nl;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        bit          md;
        int          lat;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset    = 1'b1;
        md_start = 1'b0;
        md_op    = OP_NONE;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        md_kill  = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_stall", 64'(md_stall), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // MULT / MULTU
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        check("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        check("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // DIV / DIVU, including divide by zero
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_MTHI, 32'h11, 32'h0);
        run_op(OP_MTLO, 32'h22, 32'h0);
        run_op(OP_DIVU, 32'd7, 32'd0);
        check("divu0_const", {hi, lo}, 64'h0000_0011_0000_0022);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        // MADD / MSUB accumulate
        run_op(OP_MTHI, 32'h0, 32'h0);
        run_op(OP_MTLO, 32'h1, 32'h0);
        run_op(OP_MADD, 32'd3, 32'd4);
        check("madd_const", {hi, lo}, 64'h0000_0000_0000_000D);
        run_op(OP_MSUB, 32'h0001_0000, 32'h0001_0000);
        check("msub_const", {hi, lo}, 64'hFFFF_FFFF_0000_000D);

        // Kill in the second busy cycle, with a start presented alongside
        pre_hi = exp_hi;
        pre_lo = exp_lo;
        @(negedge clk);
        md_start = 1'b1;
        md_op    = OP_MULT;
        rs_val   = 32'd9;
        rt_val   = 32'd9;
        @(negedge clk);
        md_start = 1'b0;
        check("kill_busy1", 64'(busy), 64'd1);
        @(negedge clk);
        md_kill  = 1'b1;
        md_start = 1'b1;
        md_op    = OP_MULT;
        rs_val   = 32'd3;
        rt_val   = 32'd5;
        #1;
        check("kill_stall", 64'(md_stall), 64'd1);
        @(negedge clk);
        md_kill  = 1'b0;
        md_start = 1'b0;
        md_op    = OP_NONE;
        check("kill_idle", 64'(busy), 64'd0);
        check("kill_hilo", {hi, lo}, {pre_hi, pre_lo});
        @(negedge clk);
        check("kill_no_start", 64'(busy), 64'd0);

        // DIV with a MULT held waiting until it completes
        model(OP_DIV, 32'd100, 32'd7, exp_hi, exp_lo, nh, nl, md, lat);
        @(negedge clk);
        md_start = 1'b1;
        md_op    = OP_DIV;
        rs_val   = 32'd100;
        rt_val   = 32'd7;
        @(negedge clk);
        md_start = 1'b0;
        for (int i = 1; i < int'(DC); i++) begin
            @(negedge clk);
            if (i == 2) begin
                md_start = 1'b1;
                md_op    = OP_MULT;
                rs_val   = 32'hFFFF_FFFD;
                rt_val   = 32'd7;
            end
            #1;
            check($sformatf("pend_busy c%0d", i), 64'(busy), 64'd1);
            check($sformatf("pend_stall c%0d", i), 64'(md_stall), 64'd1);
        end
        @(negedge clk);
        exp_hi = nh;
        exp_lo = nl;
        check("pend_div_done", 64'(busy), 64'd0);
        check("pend_div_hilo", {hi, lo}, {exp_hi, exp_lo});
        check("pend_div_const", {hi, lo}, 64'h0000_0002_0000_000E);
        check("pend_stall_held", 64'(md_stall), 64'd1);
        model(OP_MULT, 32'hFFFF_FFFD, 32'd7, exp_hi, exp_lo, nh, nl, md, lat);
        @(negedge clk);
        md_start = 1'b0;
        md_op    = OP_NONE;
        for (int i = 0; i < int'(MC); i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("pend_mult_busy c%0d", i), 64'(busy), 64'd1);
        end
        @(negedge clk);
        exp_hi = nh;
        exp_lo = nl;
        check("pend_mult_idle", 64'(busy), 64'd0);
        check("pend_mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        // Asynchronous reset in the third cycle of a DIV
        @(negedge clk);
        md_start = 1'b1;
        md_op    = OP_DIV;
        rs_val   = 32'd50;
        rt_val   = 32'd3;
        @(negedge clk);
        md_start = 1'b0;
        md_op    = OP_NONE;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        run_op(OP_MULT, 32'd6, 32'd7);
        check("post_rst_mult", {hi, lo}, 64'd42);

        // Randomized operations against the reference model
        for (int n = 0; n < 30; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
            run_op(rop, ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer owning the HI/LO architectural registers of the pipelined MIPS core. Sits in the E stage beside the ALU. Accepts one HI/LO-class operation at a time and models fixed multi-cycle latency with a busy flag. Exports a stall term that the hazard unit ORs into the D-stage freeze for any instruction flagged as using the multiply/divide unit.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (≥1)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- md_start  in  1  E-stage instruction is a valid HI/LO operation this cycle
- md_op  in  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO, 11–15 treated as none
- rs_val  in  32  forwarded rs operand (multiplicand/dividend; MTHI/MTLO source)
- rt_val  in  32  forwarded rt operand (multiplier/divisor)
- md_kill  in  1  exception/flush: abort the in-flight operation
- busy  out  1  operation in flight
- md_stall  out  1  combinational: busy | (md_start & md_op in 1..8)
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY. A down-counter, wide enough for max(MULT_CYCLES, DIV_CYCLES), holds the remaining cycles.
- IDLE, md_start, md_op 1–8, md_kill=0: latch the opcode and compute the full 64-bit result from rs_val/rt_val and the current hi/lo. Load the counter with the latency and go to BUSY.
- Result rules:
  - MULT: signed 32×32→64.
  - MULTU: unsigned 32×32→64.
  - MADD/MSUB: {hi,lo} ± signed product, mod 2^64.
  - MADDU/MSUBU: the same with an unsigned product.
  - DIV: signed; quotient truncated toward zero into lo, remainder (sign of dividend) into hi. 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (rt_val=0): takes the full DIV_CYCLES; hi/lo are left unchanged at completion.
- BUSY: decrement the counter each cycle. On the cycle the counter reaches 1, the next edge commits the result to hi/lo, clears busy and returns to IDLE.
- MTHI/MTLO, IDLE, md_start: write rs_val to hi or lo at the next edge; busy stays 0; no stall.
- md_start while BUSY: ignored, no state change. The hazard unit guarantees the instruction is held by md_stall.
- md_kill while BUSY: discard the pending result, hi/lo unchanged, IDLE at the next edge.
- md_kill together with md_start: the start is ignored.
- md_op none or 11–15 with md_start: no effect.

## Timing
- Reset values: busy=0, hi=0, lo=0, state IDLE, counter 0. Asynchronous reset mid-operation drops the operation immediately.
- For a mult-class start accepted at edge t0:
  - busy=1 from t0 through edge t0+MULT_CYCLES.
  - At edge t0+MULT_CYCLES, hi/lo take the result and busy=0.
  - Divides follow the same pattern with DIV_CYCLES.
- An MFHI/MFLO in E reads hi/lo combinationally. It is held by md_stall until the cycle after busy falls, then sees the new values.
- A start is accepted on the same edge that busy falls only if that cycle's md_stall allows it, i.e. the next cycle. Back-to-back throughput is one op per (latency+1) cycles.
- MTHI/MTLO: one-cycle write latency; visible to an MFHI/MFLO in E on the following cycle.
- md_stall asserts in the start cycle itself, so the dependent D-stage instruction never samples stale hi/lo.

## Test plan
- MULT rs=0xFFFFFFFF rt=0x00000002 → busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (−7) rt=0x00000002 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/0 with prior hi=0x11, lo=0x22 → after 10 cycles hi=0x11, lo=0x22.
- MTHI 0 and MTLO 1, then MADD 3×4 → lo=0x0000000D, hi=0. Then MSUB 0x10000×0x10000 → {hi,lo}=0xFFFFFFFF_0000000D.
- Start MULT, assert md_kill at cycle 2 of BUSY → busy=0 next cycle, hi/lo keep pre-op values. A new md_start in that same kill cycle is ignored.
- Start DIV; a second md_start (MULT) while busy → ignored and md_stall=1 throughout. After completion, re-present the MULT → accepted, correct result 5 cycles later.
- Assert reset asynchronously at cycle 3 of a DIV → busy, hi and lo go to 0 without waiting for a clock edge. A new MULT after reset deasserts completes normally.
